// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer
// Steps through the fixed WM8731 register table and hands each write to the
// I2C byte-write engine over a req/done/err handshake. NACKed or timed-out
// writes are retried. The block then reports init_finish on success or
// init_error on failure. Both flags stay high until reset.
module codec_config_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         MAX_RETRY      = 3,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    output logic        wr_req,
    output logic [23:0] wr_data,
    input  logic        wr_done,
    input  logic        wr_err,
    output logic [3:0]  reg_index,
    output logic        init_finish,
    output logic        init_error
);

    localparam int NUM_ENTRIES = 11;
    localparam int CNT_MAX     = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [3:0]         IDX_END      = 4'(NUM_ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         idx;
    logic [RETRY_W-1:0] retry;
    logic [CNT_W-1:0]   cnt;
    logic               err;

    // The register table. Each entry is {reg_addr[6:0], reg_data[8:0]}.
    // R9 (activate) is written last, after all other setup is in place.
    function automatic logic [15:0] table_entry(input logic [3:0] i);
        case (i)
            4'd0:    table_entry = {7'd15, 9'h000};
            4'd1:    table_entry = {7'd6,  9'h000};
            4'd2:    table_entry = {7'd0,  9'h017};
            4'd3:    table_entry = {7'd1,  9'h017};
            4'd4:    table_entry = {7'd2,  9'h079};
            4'd5:    table_entry = {7'd3,  9'h079};
            4'd6:    table_entry = {7'd4,  9'h012};
            4'd7:    table_entry = {7'd5,  9'h000};
            4'd8:    table_entry = {7'd7,  9'h002};
            4'd9:    table_entry = {7'd8,  9'h000};
            4'd10:   table_entry = {7'd9,  9'h001};
            default: table_entry = 16'h0000;
        endcase
    endfunction

    // A write fails on a NACK or when the engine stays silent for too long.
    // An error wins over a done pulse that arrives in the same cycle.
    assign err       = wr_err | (cnt == TIMEOUT_LAST);
    assign reg_index = idx;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the values from before the edge and process order has no effect.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: give a default before the case so that no path leaves
        // state_next unassigned; otherwise synthesis would infer a latch.
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_REQ;
            S_REQ:  state_next = S_WAIT;
            S_WAIT: begin
                if (err)          state_next = (retry < RETRY_LIMIT) ? S_GAP : S_FAIL;
                else if (wr_done) state_next = S_GAP;
            end
            S_GAP:  if (cnt == GAP_LAST) state_next = (idx == IDX_END) ? S_DONE : S_LOAD;
            S_DONE: state_next = S_DONE;
            S_FAIL: state_next = S_FAIL;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: table index, retry count, shared timeout/gap counter and
    // write word. The Moore outputs are registered from state_next, so each
    // one comes straight from a flop and matches the state it belongs to.
    always_ff @(posedge Clk) begin
        if (reset) begin
            idx         <= '0;
            retry       <= '0;
            cnt         <= '0;
            wr_data     <= '0;
            wr_req      <= 1'b0;
            init_finish <= 1'b0;
            init_error  <= 1'b0;
        end else begin
            wr_req      <= (state_next == S_REQ);
            init_finish <= (state_next == S_DONE);
            init_error  <= (state_next == S_FAIL);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        retry <= '0;
                    end
                end
                S_LOAD: wr_data <= {DEV_ADDR, 1'b0, table_entry(idx)};
                S_REQ:  cnt <= '0;
                S_WAIT: begin
                    if (err) begin
                        cnt <= '0;
                        if (retry < RETRY_LIMIT) retry <= retry + RETRY_W'(1);
                    end else if (wr_done) begin
                        cnt   <= '0;
                        idx   <= idx + 4'd1;
                        retry <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_GAP:  cnt <= cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// tb_codec_config_sequencer
// Directed scenarios against the codec configuration sequencer. Each expected
// request (wr_data, reg_index) goes into a queue before the DUT can issue it.
// A monitor process pops one entry on every wr_req pulse and compares it.
module tb_codec_config_sequencer;

    localparam int GAP     = 16;
    localparam int TIMEOUT = 64;

    logic        Clk;
    logic        reset;
    logic        start;
    logic        wr_req;
    logic [23:0] wr_data;
    logic        wr_done;
    logic        wr_err;
    logic [3:0]  reg_index;
    logic        init_finish;
    logic        init_error;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  idx;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          req_count = 0;
    logic [23:0] exp_data [11];

    codec_config_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
        .start      (start),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .reg_index  (reg_index),
        .init_finish(init_finish),
        .init_error (init_error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each request must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (!reset && wr_req === 1'b1) begin
            exp_t e;
            req_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("req_wr_data", 32'(wr_data), 32'(e.data));
                check("req_reg_index", 32'(reg_index), 32'(e.idx));
            end
        end
    end

    task automatic push_exp(input int i);
        exp_t e;
        e.data = exp_data[i];
        e.idx  = 4'(i);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        reset   = 1'b1;
        start   = 1'b0;
        wr_done = 1'b0;
        wr_err  = 1'b0;
        repeat (2) @(negedge Clk);
        reset = 1'b0;
    endtask

    // Waits at negedges for a wr_req, up to a fixed number of cycles.
    task automatic wait_req(output int cyc);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (wr_req !== 1'b1 && cyc < 200);
        if (wr_req !== 1'b1) check("wr_req_seen", 32'(wr_req), 32'd1);
    endtask

    task automatic pulse(input logic d, input logic e);
        wr_done = d;
        wr_err  = e;
        @(negedge Clk);
        wr_done = 1'b0;
        wr_err  = 1'b0;
    endtask

    // One handshake: expect a request for entry i, then answer 5 cycles later.
    task automatic txn(input int i, input logic d, input logic e);
        int cyc;
        push_exp(i);
        wait_req(cyc);
        repeat (5) @(negedge Clk);
        pulse(d, e);
    endtask

    initial begin
        int cyc;
        int base;

        exp_data = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                     24'h340812, 24'h340A00, 24'h340E02, 24'h341000, 24'h341201};
        reset   = 1'b1;
        start   = 1'b0;
        wr_done = 1'b0;
        wr_err  = 1'b0;

        // Reset state
        apply_reset();
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_reg_index", 32'(reg_index), 32'd0);
        check("rst_init_finish", 32'(init_finish), 32'd0);
        check("rst_init_error", 32'(init_error), 32'd0);

        // 1: nominal sequence; first request two cycles after start is sampled
        base  = req_count;
        start = 1'b1;
        push_exp(0);
        wait_req(cyc);
        check("start_latency", 32'(cyc), 32'd2);
        repeat (5) @(negedge Clk);
        pulse(1'b1, 1'b0);
        for (int i = 1; i < 11; i++) txn(i, 1'b1, 1'b0);
        repeat (GAP - 1) @(negedge Clk);
        check("nom_finish_early", 32'(init_finish), 32'd0);
        @(negedge Clk);
        check("nom_finish", 32'(init_finish), 32'd1);
        check("nom_error", 32'(init_error), 32'd0);
        check("nom_index_sat", 32'(reg_index), 32'd11);
        check("nom_req_total", 32'(req_count - base), 32'd11);
        repeat (30) @(negedge Clk);
        check("nom_finish_sticky", 32'(init_finish), 32'd1);
        check("nom_queue_drained", 32'(exp_q.size()), 32'd0);

        // 2: retry at idx 3; start is dropped mid-run and must not abort
        apply_reset();
        base  = req_count;
        start = 1'b1;
        txn(0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 1; i < 3; i++) txn(i, 1'b1, 1'b0);
        txn(3, 1'b0, 1'b1);
        txn(3, 1'b0, 1'b1);
        for (int i = 3; i < 11; i++) txn(i, 1'b1, 1'b0);
        repeat (GAP + 2) @(negedge Clk);
        check("retry_finish", 32'(init_finish), 32'd1);
        check("retry_req_total", 32'(req_count - base), 32'd13);
        check("retry_queue_drained", 32'(exp_q.size()), 32'd0);

        // 3: every attempt NACKed -> four attempts, then terminal failure
        apply_reset();
        base  = req_count;
        start = 1'b1;
        for (int k = 0; k < 4; k++) txn(0, 1'b0, 1'b1);
        repeat (150) @(negedge Clk);
        check("exh_error", 32'(init_error), 32'd1);
        check("exh_finish", 32'(init_finish), 32'd0);
        check("exh_req_total", 32'(req_count - base), 32'd4);
        check("exh_index", 32'(reg_index), 32'd0);

        // 4: engine silent -> re-request every TIMEOUT+GAP+2 cycles
        apply_reset();
        base  = req_count;
        start = 1'b1;
        push_exp(0);
        wait_req(cyc);
        for (int k = 1; k < 4; k++) begin
            push_exp(0);
            wait_req(cyc);
            check("tmo_interval", 32'(cyc), 32'(TIMEOUT + GAP + 2));
        end
        repeat (TIMEOUT) @(negedge Clk);
        check("tmo_error_early", 32'(init_error), 32'd0);
        @(negedge Clk);
        check("tmo_error", 32'(init_error), 32'd1);
        repeat (100) @(negedge Clk);
        check("tmo_req_total", 32'(req_count - base), 32'd4);

        // 5: done+err together count as an error (retry=1); a stray done
        //    during GAP is ignored, so three more errors exhaust the entry
        apply_reset();
        base  = req_count;
        start = 1'b1;
        txn(0, 1'b1, 1'b1);
        repeat (3) @(negedge Clk);
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) txn(0, 1'b0, 1'b1);
        repeat (30) @(negedge Clk);
        check("coll_error", 32'(init_error), 32'd1);
        check("coll_index", 32'(reg_index), 32'd0);
        check("coll_req_total", 32'(req_count - base), 32'd4);

        // 6: reset in WAIT at idx 5, then replay from the first entry
        apply_reset();
        start = 1'b1;
        for (int i = 0; i < 5; i++) txn(i, 1'b1, 1'b0);
        push_exp(5);
        wait_req(cyc);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check("mid_rst_wr_req", 32'(wr_req), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check("mid_rst_reg_index", 32'(reg_index), 32'd0);
        check("mid_rst_finish", 32'(init_finish), 32'd0);
        check("mid_rst_error", 32'(init_error), 32'd0);
        reset = 1'b0;
        push_exp(0);
        wait_req(cyc);
        check("replay_latency", 32'(cyc), 32'd2);
        @(negedge Clk);
        check("replay_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
